// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mac_pkg
// Brief    : Shared widths and the result-FIFO word for the MAC result path.
// Revision : 1.0 - initial release
// ============================================================================
package mac_pkg;

  localparam int ACC_W       = 16;
  localparam int MAC_LATENCY = 4;
  // Widest count the FIFO word can carry; narrower CNT_W values are zero-extended.
  localparam int CNT_MAX_W   = 16;

  typedef struct packed {
    logic                 sat;
    logic [CNT_MAX_W-1:0] count;
    logic [ACC_W-1:0]     data;
  } mac_result_t;

endpackage
`default_nettype wire

// File: rtl/mac_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_fifo
// Brief    : Synchronous FIFO of mac_result_t words; a push while full lands
//            only when a pop frees the head slot in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mac_result_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  mac_result_t wdata,
  output mac_result_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  mac_result_t   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit separates full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_collector
// Brief    : Turns the free-running MAC sum into per-vector, requantised
//            results queued behind a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module mac_result_collector
  import mac_pkg::*;
#(
  parameter int LATENCY = MAC_LATENCY,
  parameter int SHIFT   = 0,
  parameter int OUT_W   = 8,
  parameter int CNT_W   = 8,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [ACC_W-1:0] mac_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((32'd1 << OUT_W) - 32'd1);

  logic [1:0]       dly [LATENCY];   // {valid, last}
  logic             tap_valid;
  logic             tap_last;
  logic [CNT_W-1:0] elem_cnt;
  logic [CNT_W-1:0] count_now;
  logic [ACC_W-1:0] baseline;
  logic [ACC_W-1:0] delta;
  logic [ACC_W-1:0] q;
  logic             capture;
  logic             pop;
  logic             full;
  logic             empty;
  mac_result_t      wdata;
  mac_result_t      rdata;
  logic             unused_rdata;

  assign tap_valid = dly[LATENCY-1][1];
  assign tap_last  = dly[LATENCY-1][0];
  assign capture   = tap_last;
  assign count_now = elem_cnt + 1'b1;
  // Modular difference lets the upstream accumulator wrap freely.
  assign delta     = mac_result - baseline;
  assign q         = delta >> SHIFT;

  always_comb begin
    wdata       = '0;
    wdata.sat   = (q > SAT_MAX);
    wdata.data  = wdata.sat ? SAT_MAX : (q & SAT_MAX);
    wdata.count = CNT_MAX_W'(count_now);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        dly[i] <= '0;
      end
      elem_cnt <= '0;
      baseline <= '0;
      overflow <= 1'b0;
    end else begin
      dly[0] <= {in_valid, in_valid & in_last};
      for (int i = 1; i < LATENCY; i++) begin
        dly[i] <= dly[i-1];
      end
      if (tap_valid) begin
        elem_cnt <= tap_last ? '0 : count_now;
      end
      if (capture) begin
        baseline <= mac_result;
        if (full && !pop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  mac_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign out_data     = rdata.data[OUT_W-1:0];
  assign out_sat      = rdata.sat;
  assign out_count    = rdata.count[CNT_W-1:0];
  // Upper word bits are zero by construction for narrow OUT_W/CNT_W.
  assign unused_rdata = &{1'b0, rdata};

endmodule
`default_nettype wire

// File: tb/tb_mac_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_result_collector
// Brief    : Directed bench for mac_result_collector with a delayed-sum MAC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_result_collector;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_last;
  logic [15:0] mac_result;
  logic        out_ready;
  logic        out_valid, out_sat, overflow;
  logic [7:0]  out_data, out_count;
  logic        out_valid2, out_sat2, overflow2;
  logic [7:0]  out_data2, out_count2;

  logic [15:0] sum_in;
  logic [15:0] pipe [LAT];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // MAC model: the cumulative sum for an element appears LAT registers later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= sum_in;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mac_result = pipe[LAT-1];

  mac_result_collector #(.LATENCY(LAT), .SHIFT(0), .OUT_W(8), .CNT_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_count(out_count), .overflow(overflow)
  );

  mac_result_collector #(.LATENCY(LAT), .SHIFT(2), .OUT_W(8), .CNT_W(8), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
    .mac_result(mac_result), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_sat(out_sat2), .out_count(out_count2), .overflow(overflow2)
  );

  typedef struct {
    int          n;
    logic [15:0] end_sum;
    int          d0;
    int          s0;
    int          d2;
    int          s2;
    int          cnt;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with inputs idle.
  task automatic feed(input int n, input logic [15:0] end_sum);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_last  = (i == n - 1);
      sum_in   = (i == n - 1) ? end_sum : sum_in + 16'd1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cyc;

    tbl[0] = '{3, 16'd60,     60, 0, 15,  0, 3};
    tbl[1] = '{2, 16'd360,   255, 1, 75,  0, 2};
    tbl[2] = '{1, 16'hFFF0,  255, 1, 255, 1, 1};
    tbl[3] = '{4, 16'h0010,   32, 0, 8,   0, 4};
    tbl[4] = '{1, 16'h0010,    0, 0, 0,   0, 1};
    tbl[5] = '{2, 16'h010F,  255, 0, 63,  0, 2};
    tbl[6] = '{1, 16'h0210,  255, 1, 64,  0, 1};

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; sum_in = '0;
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_data", {24'd0, out_data}, 0);
    check("rst_sat", {31'd0, out_sat}, 0);
    check("rst_count", {24'd0, out_count}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_valid", {31'd0, out_valid}, 0);
    check("post_rst_data", {24'd0, out_data}, 0);
    check("post_rst_overflow", {31'd0, overflow}, 0);

    foreach (tbl[k]) begin
      feed(tbl[k].n, tbl[k].end_sum);
      wait_out(cyc);
      check($sformatf("v%0d_latency", k), cyc, LAT);
      check($sformatf("v%0d_data", k), {24'd0, out_data}, tbl[k].d0);
      check($sformatf("v%0d_sat", k), {31'd0, out_sat}, tbl[k].s0);
      check($sformatf("v%0d_count", k), {24'd0, out_count}, tbl[k].cnt);
      check($sformatf("v%0d_valid_sh2", k), {31'd0, out_valid2}, 1);
      check($sformatf("v%0d_data_sh2", k), {24'd0, out_data2}, tbl[k].d2);
      check($sformatf("v%0d_sat_sh2", k), {31'd0, out_sat2}, tbl[k].s2);
      check($sformatf("v%0d_count_sh2", k), {24'd0, out_count2}, tbl[k].cnt);
      pop_one();
      check($sformatf("v%0d_drained", k), {31'd0, out_valid}, 0);
    end

    // Bubbles between elements with the sum held steady.
    in_valid = 1'b1; in_last = 1'b0; sum_in = sum_in + 16'd5;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    idle(2);
    in_valid = 1'b1; in_last = 1'b1; sum_in = sum_in + 16'd7;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    wait_out(cyc);
    check("bubble_valid", {31'd0, out_valid}, 1);
    check("bubble_data", {24'd0, out_data}, 12);
    check("bubble_count", {24'd0, out_count}, 2);
    pop_one();

    // Fill the FIFO, then land a capture on the same edge as a pop.
    for (int k = 1; k <= 4; k++) feed(1, sum_in + 16'(k));
    idle(LAT + 2);
    check("full_head", {24'd0, out_data}, 1);
    feed(1, sum_in + 16'd5);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    idle(LAT);
    check("full_pop_no_overflow", {31'd0, overflow}, 0);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("full_pop_entry%0d", k), {24'd0, out_data}, k);
      pop_one();
    end
    check("full_pop_drained", {31'd0, out_valid}, 0);

    // Five back-to-back captures into a 4-deep FIFO with no consumer.
    for (int k = 6; k <= 10; k++) feed(1, sum_in + 16'(k));
    idle(LAT + 2);
    check("ovf_flag", {31'd0, overflow}, 1);
    check("ovf_flag_sh2", {31'd0, overflow2}, 1);
    for (int k = 6; k <= 9; k++) begin
      check($sformatf("ovf_entry%0d", k), {24'd0, out_data}, k);
      check($sformatf("ovf_count%0d", k), {24'd0, out_count}, 1);
      pop_one();
    end
    check("ovf_drained", {31'd0, out_valid}, 0);
    idle(3);
    check("ovf_sticky", {31'd0, overflow}, 1);

    // Reset in the middle of a vector; the MAC model shares the reset.
    in_valid = 1'b1; in_last = 1'b0; sum_in = sum_in + 16'd3;
    @(posedge clk); @(negedge clk);
    sum_in = sum_in + 16'd3;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1; sum_in = '0;
    idle(2);
    reset = 1'b0;
    idle(LAT + 3);
    check("midrst_no_entry", {31'd0, out_valid}, 0);
    check("midrst_overflow", {31'd0, overflow}, 0);
    feed(1, 16'd7);
    wait_out(cyc);
    check("midrst_latency", cyc, LAT);
    check("midrst_data", {24'd0, out_data}, 7);
    check("midrst_count", {24'd0, out_count}, 1);
    check("midrst_sat", {31'd0, out_sat}, 0);
    check("midrst_data_sh2", {24'd0, out_data2}, 1);
    pop_one();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
